modexp_ctrl: RTL

- Sequences one shared Montgomery multiplier (R = 2^WIDTH, handshake start/finish) to compute result = msg^exp mod modulus.
- Uses left-to-right square-and-multiply.
- Sits between the RSA top-level register file and the multiplier instance; this block owns the multiplier's A/B/N operands and start strobe.
- Host supplies r2 = R^2 mod modulus. Modulus must be odd and greater than 1.

---
 rtl/rsa_pkg.sv | 13 +
 rtl/modexp_mm_port.sv | 61 ++++++
 rtl/modexp_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA modular-exponentiation datapath.
package rsa_pkg;

    localparam int MODEXP_WIDTH     = 256;
    localparam int MODEXP_EXP_WIDTH = 256;

    typedef enum logic [3:0] {
        IDLE, PRE_M, PRE_X, SCAN, SQR, MUL, NEXT, POST, FIX, DONE
    } state_t;

    typedef enum logic {ISSUE, WAIT} phase_t;

endpackage

// File: rtl/modexp_mm_port.sv
// Issue/wait handshake toward the shared Montgomery multiplier.
// A request latches the operands and emits a one-cycle mm_start. The
// operands are then held until mm_done arrives in WAIT. rsp_vld is a
// same-cycle qualification of mm_done, so the controller registers the
// product on that edge and can issue the next request one cycle later.
module modexp_mm_port
    import rsa_pkg::*;
#(
    parameter int WIDTH = MODEXP_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             active,
    output logic             rsp_vld,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_n,
    output logic             mm_start,
    input  logic             mm_done,
    input  logic [WIDTH-1:0] mm_result
);

    phase_t phase;

    // Finish pulses outside WAIT (idle or ISSUE cycle) are ignored.
    assign rsp_vld  = active && (phase == WAIT) && mm_done;
    assign rsp_data = mm_result;

    // Handshake sequencing: idle -> ISSUE (start pulse) -> WAIT (hold) -> idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            phase    <= ISSUE;
            mm_start <= 1'b0;
            mm_a     <= '0;
            mm_b     <= '0;
            mm_n     <= '0;
        end else if (!active) begin
            if (req) begin
                mm_a     <= a;
                mm_b     <= b;
                mm_n     <= n;
                mm_start <= 1'b1;
                active   <= 1'b1;
                phase    <= ISSUE;
            end
        end else if (phase == ISSUE) begin
            mm_start <= 1'b0;
            phase    <= WAIT;
        end else if (mm_done) begin
            active <= 1'b0;
            phase  <= ISSUE;
        end
    end

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply controller computing msg^exp mod N
// using one external Montgomery multiplier (R = 2^WIDTH). Operands are
// brought into the Montgomery domain with r2 = R^2 mod N, and leave it
// through a final multiply by 1 plus a single conditional subtract.
module modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH     = MODEXP_WIDTH,
    parameter int EXP_WIDTH = MODEXP_EXP_WIDTH,
    parameter int IDX_W     = $clog2(EXP_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     msg,
    input  logic [EXP_WIDTH-1:0] exp,
    input  logic [WIDTH-1:0]     modulus,
    input  logic [WIDTH-1:0]     r2,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    output logic [WIDTH-1:0]     mm_n,
    output logic                 mm_start,
    input  logic                 mm_done,
    input  logic [WIDTH-1:0]     mm_result
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_WIDTH - 1);

    typedef struct packed {
        logic [WIDTH-1:0]     msg;
        logic [EXP_WIDTH-1:0] exp;
        logic [WIDTH-1:0]     modulus;
        logic [WIDTH-1:0]     r2;
    } job_t;

    job_t             job;
    state_t           state;
    logic [WIDTH-1:0] mbar;
    logic [WIDTH-1:0] x;
    logic [IDX_W-1:0] idx;

    logic             mul_state;
    logic             mul_req;
    logic             port_active;
    logic             rsp_vld;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] rsp_data;

    // Operand selection for whichever multiply the current state performs.
    always_comb begin
        mul_state = 1'b0;
        op_a      = '0;
        op_b      = '0;
        case (state)
            PRE_M: begin mul_state = 1'b1; op_a = job.msg; op_b = job.r2; end
            PRE_X: begin mul_state = 1'b1; op_a = ONE;     op_b = job.r2; end
            SQR:   begin mul_state = 1'b1; op_a = x;       op_b = x;      end
            MUL:   begin mul_state = 1'b1; op_a = x;       op_b = mbar;   end
            POST:  begin mul_state = 1'b1; op_a = x;       op_b = ONE;    end
            default: ;
        endcase
    end

    // Each multiply state leaves on its product, so one request per entry.
    assign mul_req = mul_state && !port_active;

    modexp_mm_port #(.WIDTH(WIDTH)) u_port (
        .clk       (clk),
        .rst       (rst),
        .req       (mul_req),
        .a         (op_a),
        .b         (op_b),
        .n         (job.modulus),
        .active    (port_active),
        .rsp_vld   (rsp_vld),
        .rsp_data  (rsp_data),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_n      (mm_n),
        .mm_start  (mm_start),
        .mm_done   (mm_done),
        .mm_result (mm_result)
    );

    // Exponentiation sequencer with registered status/result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            job    <= '0;
            mbar   <= '0;
            x      <= '0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    job   <= '{msg: msg, exp: exp, modulus: modulus, r2: r2};
                    idx   <= IDX_TOP;
                    busy  <= 1'b1;
                    state <= PRE_M;
                end
                PRE_M: if (rsp_vld) begin
                    mbar  <= rsp_data;
                    state <= PRE_X;
                end
                PRE_X: if (rsp_vld) begin
                    x     <= rsp_data;
                    state <= SCAN;
                end
                // Skip leading zeros; an all-zero exponent goes straight to POST.
                SCAN: begin
                    if (job.exp[idx])   state <= SQR;
                    else if (idx == '0) state <= POST;
                    else                idx   <= idx - 1'b1;
                end
                SQR: if (rsp_vld) begin
                    x     <= rsp_data;
                    state <= job.exp[idx] ? MUL : NEXT;
                end
                MUL: if (rsp_vld) begin
                    x     <= rsp_data;
                    state <= NEXT;
                end
                NEXT: begin
                    if (idx == '0) state <= POST;
                    else begin
                        idx   <= idx - 1'b1;
                        state <= SQR;
                    end
                end
                POST: if (rsp_vld) begin
                    x     <= rsp_data;
                    state <= FIX;
                end
                // The multiplier may return exactly N; fold it back to 0.
                FIX: begin
                    result <= (x >= job.modulus) ? x - job.modulus : x;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
